// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC and a direct-mapped I-cache.
// Misses fetch one word from the memory controller and refill the cache.
module if_stage #(
    parameter int ICACHE_IDX_W = 7,
    parameter int TAG_W        = 32 - ICACHE_IDX_W - 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [5:0]  stall_in,
    input  logic        pcJump_in,
    input  logic [31:0] pcTarget_in,
    input  logic        memDone_in,
    input  logic [31:0] memInst_in,
    output logic        memReq_out,
    output logic [31:0] memAddr_out,
    output logic        stallReq_out,
    output logic        instE_out,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out
);

    localparam int ENTRIES = 1 << ICACHE_IDX_W;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state;

    logic [31:0]             pc;
    logic                    discard;
    logic [ENTRIES-1:0]      valid;
    logic [TAG_W-1:0]        tags [ENTRIES];
    logic [31:0]             data [ENTRIES];

    logic [ICACHE_IDX_W-1:0] idx;
    logic [ICACHE_IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0]        tag;
    logic [TAG_W-1:0]        fill_tag;
    logic                    hit;
    logic                    fill;
    logic                    unused_stall;

    assign idx          = pc[ICACHE_IDX_W+1:2];
    assign tag          = pc[31:ICACHE_IDX_W+2];
    assign fill_idx     = memAddr_out[ICACHE_IDX_W+1:2];
    assign fill_tag     = memAddr_out[31:ICACHE_IDX_W+2];
    assign hit          = valid[idx] && (tags[idx] == tag);
    assign fill         = (state == WAIT) && memDone_in && !rst_in;
    assign unused_stall = ^stall_in[5:1];

    // Data and tag arrays need no reset; the valid bits gate them.
    always_ff @(posedge clk_in) begin
        if (fill) begin
            tags[fill_idx] <= fill_tag;
            data[fill_idx] <= memInst_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= IDLE;
            pc           <= '0;
            discard      <= 1'b0;
            valid        <= '0;
            memReq_out   <= 1'b0;
            memAddr_out  <= '0;
            stallReq_out <= 1'b0;
            instE_out    <= 1'b0;
            pc_out       <= '0;
            inst_out     <= '0;
        end else begin
            instE_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pcJump_in) begin
                        pc <= pcTarget_in;
                    end else if (!stall_in[0]) begin
                        if (hit) begin
                            instE_out <= 1'b1;
                            pc_out    <= pc;
                            inst_out  <= data[idx];
                            pc        <= pc + 32'd4;
                        end else begin
                            memReq_out   <= 1'b1;
                            memAddr_out  <= pc;
                            stallReq_out <= 1'b1;
                            discard      <= 1'b0;
                            state        <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (memDone_in) begin
                        valid[fill_idx] <= 1'b1;
                        memReq_out      <= 1'b0;
                        stallReq_out    <= 1'b0;
                        state           <= IDLE;
                        if (pcJump_in) begin
                            pc <= pcTarget_in;
                        end else if (!discard && !stall_in[0]) begin
                            instE_out <= 1'b1;
                            pc_out    <= memAddr_out;
                            inst_out  <= memInst_in;
                            pc        <= memAddr_out + 32'd4;
                        end
                    end else if (pcJump_in) begin
                        // Controller cannot cancel: let the fill land, drop it.
                        pc      <= pcTarget_in;
                        discard <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
